// File: rtl/addsub_pkg.sv
// addsub_pkg: op and state encodings shared by the accumulator and its bench
package addsub_pkg;
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_NOP  = 2'b11
  } op_t;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;
  localparam logic [3:0] CNT_MAX = 4'd15;
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return c == CNT_MAX ? c : c + 4'd1;
  endfunction
endpackage

// File: rtl/addsub_core.sv
// addsub_core: shared adder, a + b (sub=0) or a + ~b + 1 (sub=1); ports a, b, sub -> sum, cout
module addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0] r;
  assign b_eff = sub ? ~b : b;
  assign r = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum = r[WIDTH-1:0];
  assign cout = r[WIDTH];
endmodule

// File: rtl/addsub_accum.sv
// addsub_accum: sequence accumulator; beats in (in_valid/in_ready/in_data/in_op/in_last), result out (out_valid/out_ready/out_data/out_flag/out_count)
module addsub_accum
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag,
  output logic [3:0]       out_count
);
  state_t state, state_d;
  op_t op;
  logic [WIDTH-1:0] acc, acc_d, sum;
  logic flag, flag_d, cout;
  logic [3:0] count, count_d;
  assign op = op_t'(in_op);
  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a(acc),
    .b(in_data),
    .sub(op == OP_SUB),
    .sum(sum),
    .cout(cout)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      flag <= 1'b0;
      count <= 4'd0;
    end else begin
      state <= state_d;
      acc <= acc_d;
      flag <= flag_d;
      count <= count_d;
    end
  end
  // on SUB the adder's carry-out is the inverse of borrow
  always_comb begin
    state_d = state;
    acc_d = acc;
    flag_d = flag;
    count_d = count;
    if (state == DONE) begin
      if (out_ready) begin
        state_d = IDLE;
        acc_d = '0;
        flag_d = 1'b0;
        count_d = 4'd0;
      end
    end else if (in_valid) begin
      acc_d = op == OP_LOAD ? in_data : op == OP_NOP ? acc : sum;
      flag_d = op == OP_ADD ? flag | cout :
               op == OP_SUB ? flag | ~cout :
               op == OP_LOAD ? 1'b0 : flag;
      count_d = sat_inc(count);
      state_d = in_last ? DONE : ACCUM;
    end
  end
  assign in_ready = state != DONE;
  assign out_valid = state == DONE;
  assign out_data = acc;
  assign out_flag = flag;
  assign out_count = count;
endmodule

// File: tb/tb_addsub_accum.sv
// tb_addsub_accum: directed self-checking bench for addsub_accum
module tb_addsub_accum;
  import addsub_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = 8'd0;
  logic [1:0] in_op = 2'b11;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic out_flag;
  logic [3:0] out_count;
  int checks = 0;
  int failures = 0;

  addsub_accum #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_op(in_op),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_flag(out_flag),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] op, input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_op = op;
    in_data = d;
    in_last = last;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_data, out_flag, out_count, in_ready} !== {1'b0, 8'd0, 1'b0, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%0d f=%b c=%0d r=%b exp v=0 d=0 f=0 c=0 r=1",
               out_valid, out_data, out_flag, out_count, in_ready);
    end
  endtask

  task automatic test_add();
    beat(OP_ADD, 8'd200, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_mid_valid got %b exp 0", out_valid);
    end
    beat(OP_ADD, 8'd100, 1'b1);
    checks++;
    if ({out_valid, out_data, out_flag, out_count} !== {1'b1, 8'd44, 1'b1, 4'd2}) begin
      failures++;
      $display("FAIL add_result got v=%b d=%0d f=%b c=%0d exp v=1 d=44 f=1 c=2",
               out_valid, out_data, out_flag, out_count);
    end
    pop();
    checks++;
    if ({out_valid, out_data, out_flag, out_count, in_ready} !== {1'b0, 8'd0, 1'b0, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL add_pop got v=%b d=%0d f=%b c=%0d r=%b exp v=0 d=0 f=0 c=0 r=1",
               out_valid, out_data, out_flag, out_count, in_ready);
    end
    beat(OP_ADD, 8'd255, 1'b0);
    beat(OP_ADD, 8'd1, 1'b1);
    checks++;
    if ({out_data, out_flag, out_count} !== {8'd0, 1'b1, 4'd2}) begin
      failures++;
      $display("FAIL add_wrap got d=%0d f=%b c=%0d exp d=0 f=1 c=2", out_data, out_flag, out_count);
    end
    pop();
  endtask

  task automatic test_sub();
    beat(OP_LOAD, 8'd5, 1'b0);
    beat(OP_SUB, 8'd7, 1'b1);
    checks++;
    if ({out_valid, out_data, out_flag, out_count} !== {1'b1, 8'd254, 1'b1, 4'd2}) begin
      failures++;
      $display("FAIL sub_borrow got v=%b d=%0d f=%b c=%0d exp v=1 d=254 f=1 c=2",
               out_valid, out_data, out_flag, out_count);
    end
    pop();
    beat(OP_LOAD, 8'd9, 1'b0);
    beat(OP_SUB, 8'd9, 1'b1);
    checks++;
    if ({out_valid, out_data, out_flag} !== {1'b1, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL sub_equal got v=%b d=%0d f=%b exp v=1 d=0 f=0", out_valid, out_data, out_flag);
    end
    pop();
    beat(OP_LOAD, 8'd50, 1'b0);
    beat(OP_SUB, 8'd20, 1'b0);
    beat(OP_NOP, 8'd99, 1'b1);
    checks++;
    if ({out_data, out_flag, out_count} !== {8'd30, 1'b0, 4'd3}) begin
      failures++;
      $display("FAIL sub_nop got d=%0d f=%b c=%0d exp d=30 f=0 c=3", out_data, out_flag, out_count);
    end
    pop();
  endtask

  task automatic test_load();
    beat(OP_ADD, 8'd255, 1'b0);
    beat(OP_LOAD, 8'd3, 1'b0);
    beat(OP_ADD, 8'd4, 1'b1);
    checks++;
    if ({out_valid, out_data, out_flag, out_count} !== {1'b1, 8'd7, 1'b0, 4'd3}) begin
      failures++;
      $display("FAIL load_result got v=%b d=%0d f=%b c=%0d exp v=1 d=7 f=0 c=3",
               out_valid, out_data, out_flag, out_count);
    end
    pop();
    beat(OP_SUB, 8'd1, 1'b0);
    beat(OP_LOAD, 8'd8, 1'b1);
    checks++;
    if ({out_data, out_flag} !== {8'd8, 1'b0}) begin
      failures++;
      $display("FAIL load_clears_flag got d=%0d f=%b exp d=8 f=0", out_data, out_flag);
    end
    pop();
  endtask

  task automatic test_hold();
    beat(OP_ADD, 8'd1, 1'b1);
    in_valid = 1'b1;
    in_op = OP_ADD;
    in_data = 8'd50;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({in_ready, out_valid, out_data, out_flag, out_count} !== {1'b0, 1'b1, 8'd1, 1'b0, 4'd1}) begin
        failures++;
        $display("FAIL hold_cycle%0d got r=%b v=%b d=%0d f=%b c=%0d exp r=0 v=1 d=1 f=0 c=1",
                 i, in_ready, out_valid, out_data, out_flag, out_count);
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    pop();
    checks++;
    if ({in_ready, out_valid, out_data, out_count} !== {1'b1, 1'b0, 8'd0, 4'd0}) begin
      failures++;
      $display("FAIL hold_release got r=%b v=%b d=%0d c=%0d exp r=1 v=0 d=0 c=0",
               in_ready, out_valid, out_data, out_count);
    end
    out_ready = 1'b1;
    beat(OP_ADD, 8'd6, 1'b0);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b0, 8'd6, 4'd1}) begin
      failures++;
      $display("FAIL ready_ignored got v=%b d=%0d c=%0d exp v=0 d=6 c=1", out_valid, out_data, out_count);
    end
    beat(OP_NOP, 8'd0, 1'b1);
    pop();
  endtask

  task automatic test_reset_mid();
    beat(OP_ADD, 8'd10, 1'b0);
    beat(OP_ADD, 8'd20, 1'b0);
    rst = 1'b1;
    beat(OP_ADD, 8'd99, 1'b1);
    rst = 1'b0;
    checks++;
    if ({out_valid, out_data, out_flag, out_count, in_ready} !== {1'b0, 8'd0, 1'b0, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid got v=%b d=%0d f=%b c=%0d r=%b exp v=0 d=0 f=0 c=0 r=1",
               out_valid, out_data, out_flag, out_count, in_ready);
    end
    beat(OP_ADD, 8'd1, 1'b1);
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 8'd1, 4'd1}) begin
      failures++;
      $display("FAIL after_reset got v=%b d=%0d c=%0d exp v=1 d=1 c=1", out_valid, out_data, out_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_data, out_count, in_ready} !== {1'b0, 8'd0, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_done got v=%b d=%0d c=%0d r=%b exp v=0 d=0 c=0 r=1",
               out_valid, out_data, out_count, in_ready);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) beat(OP_NOP, 8'(i), 1'b0);
    checks++;
    if ({out_valid, out_count} !== {1'b0, 4'd15}) begin
      failures++;
      $display("FAIL sat_mid got v=%b c=%0d exp v=0 c=15", out_valid, out_count);
    end
    beat(OP_NOP, 8'd7, 1'b1);
    checks++;
    if ({out_valid, out_data, out_flag, out_count} !== {1'b1, 8'd0, 1'b0, 4'd15}) begin
      failures++;
      $display("FAIL sat_result got v=%b d=%0d f=%b c=%0d exp v=1 d=0 f=0 c=15",
               out_valid, out_data, out_flag, out_count);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_load();
    test_hold();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/addsub_accum.md
ADDSUB_ACCUM -- requirements
Module: addsub_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/accumulator width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand beat present.
REQ-005 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  unsigned operand.
REQ-007 SHALL have port in_op  input  2  00 ADD, 01 SUB, 10 LOAD, 11 NOP.
REQ-008 SHALL have port in_last  input  1  final beat of a sequence.
REQ-009 SHALL have port out_valid  output  1  sequence result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_data  output  WIDTH  accumulated result.
REQ-012 SHALL have port out_flag  output  1  sticky carry/borrow seen in sequence.
REQ-013 SHALL have port out_count  output  4  accepted beats in sequence, saturating at 15.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 SHALL assert in_ready in IDLE and ACCUM, deassert in DONE.
REQ-016 SHALL accept a beat only on in_valid & in_ready; no accept -> no state change.
REQ-017 SHALL start each sequence with acc=0, flag=0, count=0 (IDLE holds these values).
REQ-018 ADD beat SHALL set acc <= (acc + in_data) mod 2^WIDTH; flag |= carry-out.
REQ-019 SUB beat SHALL set acc <= (acc - in_data) mod 2^WIDTH; flag |= borrow (acc < in_data).
REQ-020 SUB SHALL be computed as acc + ~in_data + 1 through the same adder as ADD (one adder, no separate subtractor).
REQ-021 LOAD beat SHALL set acc <= in_data and clear flag.
REQ-022 NOP beat SHALL leave acc and flag unchanged.
REQ-023 Every accepted beat (any op) SHALL increment count, saturating at 15.
REQ-024 Accept without in_last SHALL move IDLE->ACCUM or stay in ACCUM.
REQ-025 Accept with in_last SHALL move to DONE from IDLE or ACCUM; a single-beat sequence is legal.
REQ-026 out_valid SHALL be 1 exactly in DONE, first asserted the cycle after the last beat is accepted (latency 1).
REQ-027 out_data/out_flag/out_count SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 DONE with out_ready=1 SHALL return to IDLE next cycle and clear acc, flag, count.
REQ-029 out_ready outside DONE SHALL be ignored.
REQ-030 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, acc=0, flag=0, count=0 regardless of state, including mid-sequence and in DONE.
REQ-032 During and the cycle after reset: out_valid=0, out_data=0, out_flag=0, out_count=0, in_ready=1.
REQ-033 A beat presented during a reset cycle SHALL be discarded.

Structure
REQ-034 Op encodings (OP_ADD, OP_SUB, OP_LOAD, OP_NOP) and state encodings SHALL reside in shared package addsub_pkg.
REQ-035 SHALL instantiate one combinational sub-module addsub_core (inputs a, b, sub; outputs sum, cout) using inverted b and carry-in = sub.
REQ-036 Borrow SHALL be derived as ~cout when sub=1.

Verification
REQ-037 ADD 200, ADD 100(last) -> out_data=44, out_flag=1, out_count=2, out_valid one cycle after last.
REQ-038 LOAD 5, SUB 7(last) -> out_data=254, out_flag=1; LOAD 9, SUB 9(last) -> out_data=0, out_flag=0.
REQ-039 ADD 255, LOAD 3, ADD 4(last) -> out_data=7, out_flag=0, out_count=3.
REQ-040 Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no beat consumed; then out_ready=1 -> IDLE next cycle.
REQ-041 rst=1 after ADD 10, ADD 20 (no last) -> next sequence ADD 1(last) gives out_data=1, out_count=1.
REQ-042 20 NOP beats then NOP(last) -> out_count=15, out_data=0, out_flag=0.
